// File: rtl/fifo_uart_tx_if.sv
// fifo_uart_tx_if: groups the FIFO read-port and UART-side signals of fifo_uart_tx.
//   tx_en       enable fetching new bytes (sampled by the drain stage in IDLE)
//   fifo_empty  FIFO empty flag
//   fifo_data   FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en  single-cycle pop request
//   tx          UART serial line, idle high
//   tx_busy     drain stage not idle
//   tx_done     pulse on the last cycle of the final stop bit
//   byte_count  frames completed, wrapping
// The slave modport is the drain stage; the master modport is its environment.
interface fifo_uart_tx_if;
    logic        tx_en;
    logic        fifo_empty;
    logic [7:0]  fifo_data;
    logic        fifo_rd_en;
    logic        tx;
    logic        tx_busy;
    logic        tx_done;
    logic [15:0] byte_count;

    modport master (
        output tx_en, fifo_empty, fifo_data,
        input  fifo_rd_en, tx, tx_busy, tx_done, byte_count
    );

    modport slave (
        input  tx_en, fifo_empty, fifo_data,
        output fifo_rd_en, tx, tx_busy, tx_done, byte_count
    );
endinterface

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains an 8-bit synchronous FIFO one byte at a time and serializes each
// byte as a UART frame (start, 8 data bits LSB first, optional parity, 1 or 2 stops).
//   clk  system clock, rising edge
//   rst  asynchronous active-high reset
//   bus  fifo_uart_tx_if.slave: tx_en, fifo_empty, fifo_data in;
//        fifo_rd_en, tx, tx_busy, tx_done, byte_count out
// Parameters: CLKS_PER_BIT (>= 2), PARITY (0 none, 1 even, 2 odd), STOP_BITS (1 or 2).
module fifo_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input logic           clk,
    input logic           rst,
    fifo_uart_tx_if.slave bus
);

    localparam int unsigned      CntW     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0]  CntLast  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       StopLast = 3'(STOP_BITS - 1);
    localparam logic             OddPar   = (PARITY == 2);

    typedef enum logic [2:0] {
        StIdle, StRead, StLoad, StStart, StData, StParity, StStop
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            par_q, par_d;
    logic            tx_q, tx_d;
    logic            done_q, done_d;
    logic [15:0]     count_q, count_d;
    logic            bit_end;

    assign bit_end = (cnt_q == CntLast);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        par_d     = par_q;
        count_d   = count_q;

        if (state_q inside {StStart, StData, StParity, StStop}) begin
            cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (bus.tx_en && !bus.fifo_empty) state_d = StRead;
            end
            StRead: state_d = StLoad;
            StLoad: begin
                // fifo_data is valid now, one cycle after the pop.
                shift_d   = bus.fifo_data;
                par_d     = (^bus.fifo_data) ^ OddPar;
                cnt_d     = '0;
                bit_idx_d = '0;
                state_d   = StStart;
            end
            StStart: begin
                if (bit_end) state_d = StData;
            end
            StData: begin
                if (bit_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        bit_idx_d = '0;
                        state_d   = (PARITY != 0) ? StParity : StStop;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            StParity: begin
                if (bit_end) begin
                    bit_idx_d = '0;
                    state_d   = StStop;
                end
            end
            StStop: begin
                if (bit_end) begin
                    if (bit_idx_q == StopLast) begin
                        bit_idx_d = '0;
                        count_d   = count_q + 16'd1;
                        state_d   = StIdle;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Registered outputs are computed from next-state values so they line up
        // with the state they describe and tx never glitches.
        unique case (state_d)
            StStart:  tx_d = 1'b0;
            StData:   tx_d = shift_d[0];
            StParity: tx_d = par_d;
            default:  tx_d = 1'b1;
        endcase

        done_d = (state_d == StStop) && (cnt_d == CntLast) && (bit_idx_d == StopLast);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
            count_q   <= count_d;
        end
    end

    assign bus.fifo_rd_en = (state_q == StRead);
    assign bus.tx_busy    = (state_q != StIdle);
    assign bus.tx         = tx_q;
    assign bus.tx_done    = done_q;
    assign bus.byte_count = count_q;

endmodule
